pl_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage pipeline: drives en (stall,

---
 rtl/pl_hazard_ctrl_pkg.sv | 31 +++
 rtl/pl_hazard_ctrl_fwd.sv | 18 +
 rtl/pl_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pl_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller:
// result-source codes, forward selects and memory FSM states.
package pl_hazard_ctrl_pkg;

    localparam logic [1:0] RES_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // M beats W; x0 is never a forwarding source
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return FWD_MEM;
        if (we_w && rd_w != 5'd0 && rd_w == rs)
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pl_hazard_ctrl_fwd.sv
// Pure combinational E-stage operand forwarding select.
module pl_fwd_unit
    import pl_hazard_ctrl_pkg::*;
(
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush priority, forwarding,
// and the valid/ready sequencer for variable-latency data memory.
module pl_hazard_ctrl
    import pl_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);

    mem_state_t    state, state_n;
    logic [WW-1:0] cnt, cnt_n;
    logic          to_hit;
    logic          req;
    logic          last;
    logic          mem_stall;
    logic          lw_stall;
    logic [1:0]    fwd_a, fwd_b;

    pl_fwd_unit u_fwd (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != 5'd0)
                   && (RdE == Rs1D || RdE == Rs2D);

    assign req       = (state == IDLE && MemReqM) || (state == WAIT);
    assign last      = (state == WAIT) && (cnt == LAST);
    assign mem_stall = req && !dmem_ready && !last;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        to_hit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (MemReqM && !dmem_ready) begin
                    state_n = WAIT;
                    cnt_n   = WW'(1);
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (last) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    to_hit  = 1'b1;
                end else begin
                    cnt_n = cnt + WW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Reset overrides everything: no stalls, all flushes, no request
    always_comb begin
        dmem_valid = 1'b0;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b1;
        FlushE     = 1'b1;
        FlushW     = 1'b1;
        if (!reset) begin
            dmem_valid = req;
            ForwardAE  = fwd_a;
            ForwardBE  = fwd_b;
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
                FlushW = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (to_hit)
                mem_timeout <= 1'b1;
            if (StallF | StallD | StallE | StallM)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed vector table plus hand-written memory handshake
// sequences for pl_hazard_ctrl (TIMEOUT=4).
module tb_pl_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready;
    logic        dmem_valid;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    int applied = 0;
    int errors  = 0;

    pl_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .RdM          (RdM),
        .RdW          (RdW),
        .ResultSrcE   (ResultSrcE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .PCSrcE       (PCSrcE),
        .MemReqM      (MemReqM),
        .dmem_ready   (dmem_ready),
        .dmem_valid   (dmem_valid),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       wm, ww, pcs;
        logic [1:0] fa, fb;
        logic       sf, sd, fd, fe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0; ResultSrcE = 2'b00;
        RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; dmem_ready = 0;
    endtask

    task automatic chk_stall(input string n, input logic s, input logic fw);
        chk({n, ".StallF"}, {31'd0, StallF}, {31'd0, s});
        chk({n, ".StallD"}, {31'd0, StallD}, {31'd0, s});
        chk({n, ".StallE"}, {31'd0, StallE}, {31'd0, s});
        chk({n, ".StallM"}, {31'd0, StallM}, {31'd0, s});
        chk({n, ".FlushW"}, {31'd0, FlushW}, {31'd0, fw});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        quiet();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        //         name     rs1d rs2d rs1e rs2e rde rdm rdw rsrc wm ww pc  fa     fb     sf sd fd fe
        tbl.push_back('{"raw_m",  1, 2, 5, 3, 0, 5, 5, 2'b00, 1, 1, 0, 2'b10, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{"raw_w",  1, 2, 5, 3, 0, 0, 5, 2'b00, 1, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{"x0",     1, 2, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{"b_w",    1, 2, 4, 9, 0, 9, 9, 2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0});
        tbl.push_back('{"ab_mw",  1, 2, 6, 8, 0, 6, 8, 2'b00, 1, 1, 0, 2'b10, 2'b01, 0, 0, 0, 0});
        tbl.push_back('{"lduse",  1, 7, 0, 0, 7, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0, 1});
        tbl.push_back('{"ld_x0",  0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{"noload", 7, 2, 0, 0, 7, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0});
        tbl.push_back('{"branch", 1, 2, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1});
        tbl.push_back('{"ld_br",  7, 2, 0, 0, 7, 0, 0, 2'b01, 0, 0, 1, 2'b00, 2'b00, 1, 1, 1, 1});

        // reset behaviour with active-looking inputs
        reset = 1'b1;
        quiet();
        MemReqM = 1; RegWriteM = 1; RdM = 5; Rs1E = 5;
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        tick();
        chk("rst.valid", {31'd0, dmem_valid}, 32'd0);
        chk("rst.fwdA", {30'd0, ForwardAE}, 32'd0);
        chk_stall("rst", 1'b0, 1'b1);
        chk("rst.FlushD", {31'd0, FlushD}, 32'd1);
        chk("rst.FlushE", {31'd0, FlushE}, 32'd1);
        tick();
        reset = 1'b0;
        quiet();
        #1;
        chk("rst.count", stall_cycles, 32'd0);
        chk("rst.timeout", {31'd0, mem_timeout}, 32'd0);

        foreach (tbl[i]) begin
            Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d;
            Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
            RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
            ResultSrcE = tbl[i].rsrc;
            RegWriteM = tbl[i].wm; RegWriteW = tbl[i].ww;
            PCSrcE = tbl[i].pcs;
            #1;
            chk({tbl[i].name, ".fwdA"}, {30'd0, ForwardAE}, {30'd0, tbl[i].fa});
            chk({tbl[i].name, ".fwdB"}, {30'd0, ForwardBE}, {30'd0, tbl[i].fb});
            chk({tbl[i].name, ".StallF"}, {31'd0, StallF}, {31'd0, tbl[i].sf});
            chk({tbl[i].name, ".StallD"}, {31'd0, StallD}, {31'd0, tbl[i].sd});
            chk({tbl[i].name, ".FlushD"}, {31'd0, FlushD}, {31'd0, tbl[i].fd});
            chk({tbl[i].name, ".FlushE"}, {31'd0, FlushE}, {31'd0, tbl[i].fe});
            chk({tbl[i].name, ".StallE"}, {31'd0, StallE}, 32'd0);
            chk({tbl[i].name, ".FlushW"}, {31'd0, FlushW}, 32'd0);
            tick();
        end

        // zero-wait access: no stall, FSM stays IDLE
        do_reset();
        MemReqM = 1; dmem_ready = 1;
        #1;
        chk("zw.valid", {31'd0, dmem_valid}, 32'd1);
        chk_stall("zw", 1'b0, 1'b0);
        tick();
        MemReqM = 0; dmem_ready = 0;
        #1;
        chk("zw.idle", {31'd0, dmem_valid}, 32'd0);
        chk("zw.count", stall_cycles, 32'd0);

        // 3-wait access with a branch masked behind the stall
        MemReqM = 1; dmem_ready = 0;
        for (int c = 1; c <= 3; c++) begin
            PCSrcE = (c >= 2);
            ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
            #1;
            chk($sformatf("w3.valid%0d", c), {31'd0, dmem_valid}, 32'd1);
            chk_stall($sformatf("w3.c%0d", c), 1'b1, 1'b1);
            chk($sformatf("w3.FlushD%0d", c), {31'd0, FlushD}, 32'd0);
            chk($sformatf("w3.FlushE%0d", c), {31'd0, FlushE}, 32'd0);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("w3.done.valid", {31'd0, dmem_valid}, 32'd1);
        chk("w3.done.StallE", {31'd0, StallE}, 32'd0);
        chk("w3.done.FlushW", {31'd0, FlushW}, 32'd0);
        chk("w3.done.FlushD", {31'd0, FlushD}, 32'd1);
        chk("w3.done.FlushE", {31'd0, FlushE}, 32'd1);
        chk("w3.done.StallF", {31'd0, StallF}, 32'd1);
        tick();
        quiet();
        #1;
        chk("w3.norepeat", {31'd0, dmem_valid}, 32'd0);
        chk("w3.count", stall_cycles, 32'd4);

        // timeout: ready never comes
        MemReqM = 1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk_stall($sformatf("to.c%0d", c), 1'b1, 1'b1);
            tick();
        end
        #1;
        chk("to.last.valid", {31'd0, dmem_valid}, 32'd1);
        chk_stall("to.last", 1'b0, 1'b0);
        chk("to.pre", {31'd0, mem_timeout}, 32'd0);
        tick();
        MemReqM = 0;
        #1;
        chk("to.flag", {31'd0, mem_timeout}, 32'd1);
        chk("to.count", stall_cycles, 32'd7);
        chk("to.valid", {31'd0, dmem_valid}, 32'd0);
        tick();
        tick();
        chk("to.sticky", {31'd0, mem_timeout}, 32'd1);

        // reset while in WAIT
        MemReqM = 1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rw.valid", {31'd0, dmem_valid}, 32'd0);
        chk_stall("rw", 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        MemReqM = 0;
        #1;
        chk("rw.idle", {31'd0, dmem_valid}, 32'd0);
        chk("rw.count", stall_cycles, 32'd0);
        chk("rw.timeout", {31'd0, mem_timeout}, 32'd0);
        MemReqM = 1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk_stall($sformatf("rw.c%0d", c), 1'b1, 1'b1);
            tick();
        end
        #1;
        chk_stall("rw.last", 1'b0, 1'b0);
        tick();
        MemReqM = 0;
        #1;
        chk("rw.count2", stall_cycles, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
